// File: rtl/csr_file_mtrap_if.sv
// CSR access, trap and interrupt signals exchanged between the core pipeline and the
// machine-mode CSR file.
interface csr_file_mtrap_if #(
    parameter int unsigned XLEN = 32
);
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            mret;
    logic            retire;
    logic            irq_ext;
    logic            irq_sw;
    logic            irq_tmr;
    logic            irq_take;
    logic [XLEN-1:0] trap_pc;
    logic            redirect;
    logic [1:0]      priv_mode;

    modport master (
        output csr_addr, csr_op, csr_wdata, exc_valid, exc_cause, exc_pc, exc_tval,
               mret, retire, irq_ext, irq_sw, irq_tmr,
        input  csr_rdata, csr_illegal, irq_take, trap_pc, redirect, priv_mode
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata, exc_valid, exc_cause, exc_pc, exc_tval,
               mret, retire, irq_ext, irq_sw, irq_tmr,
        output csr_rdata, csr_illegal, irq_take, trap_pc, redirect, priv_mode
    );
endinterface

// File: rtl/csr_file_mtrap.sv
// Machine-mode CSR file for the single-hart RV32 core: CSR read/modify/write, M/U privilege,
// mcycle/minstret, interrupt prioritisation and trap/mret redirect target.
module csr_file_mtrap #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_W       = 64,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic             clk,
    input  logic             reset_x,
    csr_file_mtrap_if.slave  bus
);
    localparam int unsigned     HI_W     = CNT_W - 32;
    localparam logic [1:0]      PRIV_M   = 2'b11;
    localparam logic [1:0]      PRIV_U   = 2'b00;
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
    localparam logic [XLEN-1:0] MISA_VAL = XLEN'(32'h4000_0100);

    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;

    logic [1:0]       priv_q, priv_d;
    logic             mst_mie_q, mst_mie_d;
    logic             mst_mpie_q, mst_mpie_d;
    logic [1:0]       mst_mpp_q, mst_mpp_d;
    logic [XLEN-1:0]  mie_q, mie_d;
    logic [XLEN-1:0]  mtvec_q, mtvec_d;
    logic [XLEN-1:0]  mscratch_q, mscratch_d;
    logic [XLEN-1:0]  mepc_q, mepc_d;
    logic [XLEN-1:0]  mcause_q, mcause_d;
    logic [XLEN-1:0]  mtval_q, mtval_d;
    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;

    csr_op_e         op;
    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] pending;
    logic            vec_mode;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wr_val;
    logic            impl;
    logic            wr_req;
    logic            illegal;
    logic            irq_en;
    logic            irq_take;
    logic [3:0]      irq_code;
    logic            csr_do_write;

    assign op        = csr_op_e'(bus.csr_op);
    assign vec_mode  = VECTORED_EN && (mtvec_q[1:0] == 2'b01);
    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

    always_comb begin
        mip     = '0;
        mip[3]  = bus.irq_sw;
        mip[7]  = bus.irq_tmr;
        mip[11] = bus.irq_ext;
    end

    // NOTE: every combinational output gets a default before the case, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        rd_val = '0;
        impl   = 1'b1;
        case (bus.csr_addr)
            12'h300: begin
                rd_val[3]     = mst_mie_q;
                rd_val[7]     = mst_mpie_q;
                rd_val[12:11] = mst_mpp_q;
            end
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = mie_q;
            12'h305: rd_val = {mtvec_q[XLEN-1:2], 1'b0, vec_mode};
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = mip;
            12'hB00: rd_val = mcycle_q[31:0];
            12'hB80: rd_val = XLEN'(mcycle_q[CNT_W-1:32]);
            12'hB02: rd_val = minstret_q[31:0];
            12'hB82: rd_val = XLEN'(minstret_q[CNT_W-1:32]);
            12'hF14: rd_val = HART_ID;
            default: impl = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not trip the read-only check.
    assign wr_req  = (op == OP_RW) || ((op == OP_RS || op == OP_RC) && (|bus.csr_wdata));
    assign illegal = (op != OP_NONE) &&
                     (!impl || (bus.csr_addr[9:8] > priv_q) ||
                      ((bus.csr_addr[11:10] == 2'b11) && wr_req));

    always_comb begin
        case (op)
            OP_RW:   wr_val = bus.csr_wdata;
            OP_RS:   wr_val = rd_val | bus.csr_wdata;
            OP_RC:   wr_val = rd_val & ~bus.csr_wdata;
            default: wr_val = rd_val;
        endcase
    end

    assign pending  = mie_q & mip;
    assign irq_en   = ((priv_q == PRIV_M) && mst_mie_q) || (priv_q == PRIV_U);
    assign irq_take = irq_en && (|pending) && !bus.exc_valid && !bus.mret;
    assign irq_code = pending[11] ? 4'd11 : (pending[3] ? 4'd3 : 4'd7);

    assign csr_do_write = wr_req && (op != OP_NONE) && !illegal &&
                          !bus.exc_valid && !irq_take && !bus.mret;

    assign bus.csr_rdata   = illegal ? '0 : rd_val;
    assign bus.csr_illegal = illegal;
    assign bus.irq_take    = irq_take;
    assign bus.redirect    = bus.exc_valid || irq_take || bus.mret;
    assign bus.priv_mode   = priv_q;

    always_comb begin
        if (bus.exc_valid)     bus.trap_pc = trap_base;
        else if (irq_take)     bus.trap_pc = vec_mode ? trap_base + XLEN'({irq_code, 2'b00}) : trap_base;
        else if (bus.mret)     bus.trap_pc = mepc_q;
        else                   bus.trap_pc = trap_base;
    end

    always_comb begin
        priv_d     = priv_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mst_mpp_d  = mst_mpp_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + CNT_W'(1);
        minstret_d = minstret_q + CNT_W'(bus.retire);

        if (bus.exc_valid || irq_take) begin
            mepc_d             = bus.exc_pc;
            mcause_d           = '0;
            mcause_d[XLEN-1]   = !bus.exc_valid;
            mcause_d[3:0]      = bus.exc_valid ? bus.exc_cause : irq_code;
            mtval_d            = bus.exc_valid ? bus.exc_tval : '0;
            mst_mpie_d         = mst_mie_q;
            mst_mie_d          = 1'b0;
            mst_mpp_d          = priv_q;
            priv_d             = PRIV_M;
        end else if (bus.mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            priv_d     = mst_mpp_q;
            mst_mpp_d  = PRIV_U;
        end else if (csr_do_write) begin
            case (bus.csr_addr)
                12'h300: begin
                    mst_mie_d  = wr_val[3];
                    mst_mpie_d = wr_val[7];
                    mst_mpp_d  = wr_val[12:11];
                end
                12'h304: mie_d      = wr_val & MIE_MASK;
                12'h305: mtvec_d    = wr_val;
                12'h340: mscratch_d = wr_val;
                12'h341: mepc_d     = {wr_val[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = wr_val;
                12'h343: mtval_d    = wr_val;
                // A half write replaces that half outright: no increment, no carry.
                12'hB00: mcycle_d   = {mcycle_q[CNT_W-1:32], wr_val};
                12'hB80: mcycle_d   = {wr_val[HI_W-1:0], mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[CNT_W-1:32], wr_val};
                12'hB82: minstret_d = {wr_val[HI_W-1:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            priv_q     <= PRIV_M;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mst_mpp_q  <= PRIV_M;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            priv_q     <= priv_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mst_mpp_q  <= mst_mpp_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
endmodule

// File: tb/tb_csr_file_mtrap.sv
// Self-checking bench for csr_file_mtrap: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an architectural model of the CSR file.
module tb_csr_file_mtrap;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 40;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0400;
    localparam logic [31:0] HART_ID   = 32'd3;
    localparam logic [63:0] CNT_MASK  = (64'd1 << CNT_W) - 64'd1;

    logic clk     = 1'b0;
    logic reset_x = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    csr_file_mtrap_if #(.XLEN(XLEN)) bus ();

    csr_file_mtrap #(
        .XLEN(XLEN), .CNT_W(CNT_W), .MTVEC_RST(MTVEC_RST), .VECTORED_EN(1'b1), .HART_ID(HART_ID)
    ) dut (
        .clk(clk), .reset_x(reset_x), .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural state as software sees it; counters kept as plain 64-bit integers.
    typedef struct {
        logic [1:0]  priv;
        logic        st_mie;
        logic        st_mpie;
        logic [1:0]  st_mpp;
        logic [31:0] mie, mtvec, mscratch, mepc, mcause, mtval;
        logic [63:0] cyc, ins;
    } model_t;

    model_t m, n;
    bit     have_next = 1'b0;

    function automatic model_t model_reset_state();
        model_t s;
        s.priv = 2'b11; s.st_mie = 1'b0; s.st_mpie = 1'b0; s.st_mpp = 2'b11;
        s.mie = 0; s.mtvec = MTVEC_RST; s.mscratch = 0; s.mepc = 0; s.mcause = 0; s.mtval = 0;
        s.cyc = 0; s.ins = 0;
        return s;
    endfunction

    function automatic bit model_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic logic [31:0] model_read(input model_t s, input logic [11:0] a,
                                               input logic [31:0] mip);
        case (a)
            12'h300: return (32'(s.st_mie) << 3) | (32'(s.st_mpie) << 7) | (32'(s.st_mpp) << 11);
            12'h301: return 32'h4000_0100;
            12'h304: return s.mie;
            12'h305: return (s.mtvec & 32'hFFFF_FFFC) | ((s.mtvec[1:0] == 2'b01) ? 32'd1 : 32'd0);
            12'h340: return s.mscratch;
            12'h341: return s.mepc;
            12'h342: return s.mcause;
            12'h343: return s.mtval;
            12'h344: return mip;
            12'hB00: return s.cyc[31:0];
            12'hB80: return s.cyc[63:32];
            12'hB02: return s.ins[31:0];
            12'hB82: return s.ins[63:32];
            12'hF14: return HART_ID;
            default: return 32'd0;
        endcase
    endfunction

    // Compare process: evaluates outputs mid-cycle, commits the model on the rising edge.
    always begin
        logic [11:0] a;
        logic [1:0]  op;
        logic [31:0] wd, mip, old, pend, base, exp_pc, nv;
        logic [3:0]  code;
        bit          wr, ill, en, take, redir;
        @(negedge clk);
        if (!reset_x) begin
            m = model_reset_state();
            have_next = 1'b0;
        end else begin
            a    = bus.csr_addr;
            op   = bus.csr_op;
            wd   = bus.csr_wdata;
            mip  = (32'(bus.irq_ext) << 11) | (32'(bus.irq_tmr) << 7) | (32'(bus.irq_sw) << 3);
            old  = model_read(m, a, mip);
            wr   = (op == 2'b01) || (op != 2'b00 && wd != 0);
            ill  = (op != 2'b00) && (!model_impl(a) || a[9:8] > m.priv || (a[11:10] == 2'b11 && wr));
            pend = m.mie & mip;
            en   = (m.priv == 2'b11 && m.st_mie) || m.priv == 2'b00;
            take = en && pend != 0 && !bus.exc_valid && !bus.mret;
            code = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
            base = m.mtvec & 32'hFFFF_FFFC;
            if (bus.exc_valid) exp_pc = base;
            else if (take)     exp_pc = (m.mtvec[1:0] == 2'b01) ? base + 32'(code) * 4 : base;
            else               exp_pc = m.mepc;
            redir = bus.exc_valid || take || bus.mret;

            check("rdata", bus.csr_rdata, ill ? 32'd0 : old);
            check("illegal", 32'(bus.csr_illegal), 32'(ill));
            check("irq_take", 32'(bus.irq_take), 32'(take));
            check("redirect", 32'(bus.redirect), 32'(redir));
            check("priv_mode", 32'(bus.priv_mode), 32'(m.priv));
            if (redir) check("trap_pc", bus.trap_pc, exp_pc);

            n = m;
            n.cyc = (m.cyc + 64'd1) & CNT_MASK;
            n.ins = (m.ins + 64'(bus.retire)) & CNT_MASK;
            if (bus.exc_valid || take) begin
                n.mepc    = bus.exc_pc;
                n.mcause  = bus.exc_valid ? 32'(bus.exc_cause) : (32'h8000_0000 | 32'(code));
                n.mtval   = bus.exc_valid ? bus.exc_tval : 32'd0;
                n.st_mpie = m.st_mie;
                n.st_mie  = 1'b0;
                n.st_mpp  = m.priv;
                n.priv    = 2'b11;
            end else if (bus.mret) begin
                n.st_mie  = m.st_mpie;
                n.st_mpie = 1'b1;
                n.priv    = m.st_mpp;
                n.st_mpp  = 2'b00;
            end else if (op != 2'b00 && !ill && wr) begin
                nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
                case (a)
                    12'h300: begin n.st_mie = nv[3]; n.st_mpie = nv[7]; n.st_mpp = nv[12:11]; end
                    12'h304: n.mie      = nv & 32'h0000_0888;
                    12'h305: n.mtvec    = nv;
                    12'h340: n.mscratch = nv;
                    12'h341: n.mepc     = nv & 32'hFFFF_FFFC;
                    12'h342: n.mcause   = nv;
                    12'h343: n.mtval    = nv;
                    12'hB00: n.cyc = {m.cyc[63:32], nv} & CNT_MASK;
                    12'hB80: n.cyc = {nv, m.cyc[31:0]} & CNT_MASK;
                    12'hB02: n.ins = {m.ins[63:32], nv} & CNT_MASK;
                    12'hB82: n.ins = {nv, m.ins[31:0]} & CNT_MASK;
                    default: ;
                endcase
            end
            have_next = 1'b1;
        end
        @(posedge clk);
        if (have_next && reset_x) m = n;
    end

    task automatic idle();
        bus.csr_addr = 12'h000; bus.csr_op = 2'b00; bus.csr_wdata = 32'd0;
        bus.exc_valid = 1'b0; bus.exc_cause = 4'd0; bus.exc_pc = 32'd0; bus.exc_tval = 32'd0;
        bus.mret = 1'b0; bus.retire = 1'b0;
        bus.irq_ext = 1'b0; bus.irq_sw = 1'b0; bus.irq_tmr = 1'b0;
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        set_csr(a, 2'b00, 32'd0); mid(); check(name, bus.csr_rdata, exp); nxt();
    endtask

    logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hF14, 12'h7C0, 12'h302};

    initial begin
        idle();
        reset_x = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_csr(12'h300, 2'b00, 0); mid();
        check("rst_mstatus", bus.csr_rdata, 32'h0000_1800);
        check("rst_priv", 32'(bus.priv_mode), 32'd3);
        nxt();
        read_chk("rst_mtvec", 12'h305, MTVEC_RST);
        read_chk("rst_mcycle", 12'hB00, 32'd0);
        reset_x = 1'b1;

        set_csr(12'h340, 2'b01, 32'hDEAD_BEEF); mid(); nxt();
        set_csr(12'h340, 2'b10, 32'h0000_0010); mid(); check("rw_value", bus.csr_rdata, 32'hDEAD_BEEF); nxt();
        set_csr(12'h340, 2'b11, 32'hF000_0000); mid(); check("rs_value", bus.csr_rdata, 32'hDEAD_BEFF); nxt();
        read_chk("rc_value", 12'h340, 32'h0EAD_BEFF);

        set_csr(12'h300, 2'b11, 32'h0000_1800); mid(); nxt();
        bus.mret = 1'b1; mid(); check("mret_to_u_pc", bus.trap_pc, 32'd0); nxt();
        set_csr(12'h300, 2'b10, 0); mid();
        check("u_priv", 32'(bus.priv_mode), 32'd0);
        check("u_read_illegal", 32'(bus.csr_illegal), 32'd1);
        check("u_read_rdata", bus.csr_rdata, 32'd0);
        nxt();
        bus.exc_valid = 1'b1; bus.exc_cause = 4'd8; bus.exc_pc = 32'h100; mid();
        check("ecall_redirect", 32'(bus.redirect), 32'd1);
        check("ecall_pc", bus.trap_pc, 32'h0000_0400);
        nxt();
        read_chk("ecall_mepc", 12'h341, 32'h100);
        read_chk("ecall_mcause", 12'h342, 32'd8);
        read_chk("ecall_mstatus", 12'h300, 32'h0);
        bus.mret = 1'b1; mid(); check("mret_pc", bus.trap_pc, 32'h100); nxt();
        mid(); check("mret_priv", 32'(bus.priv_mode), 32'd0); nxt();

        bus.exc_valid = 1'b1; bus.exc_cause = 4'd8; bus.exc_pc = 32'h104; mid(); nxt();
        set_csr(12'h305, 2'b01, 32'h0000_2001); mid(); nxt();
        set_csr(12'h304, 2'b01, 32'h0000_0888); mid(); nxt();
        set_csr(12'h300, 2'b10, 32'h0000_0008); mid(); nxt();
        read_chk("mtvec_vec", 12'h305, 32'h0000_2001);
        bus.irq_tmr = 1'b1; bus.irq_ext = 1'b1; bus.exc_pc = 32'h500;
        set_csr(12'h344, 2'b00, 0); mid();
        check("irq_take", 32'(bus.irq_take), 32'd1);
        check("irq_vec_pc", bus.trap_pc, 32'h0000_202C);
        check("mip_live", bus.csr_rdata, 32'h0000_0880);
        nxt();
        read_chk("irq_mcause", 12'h342, 32'h8000_000B);
        read_chk("irq_mepc", 12'h341, 32'h500);
        read_chk("irq_mtval", 12'h343, 32'd0);
        read_chk("irq_mstatus", 12'h300, 32'h0000_1880);

        set_csr(12'hB80, 2'b01, 0); mid(); nxt();
        set_csr(12'hB00, 2'b01, 32'hFFFF_FFFF); mid(); nxt();
        read_chk("carry_hi_before", 12'hB80, 32'd0);
        read_chk("carry_hi_after", 12'hB80, 32'd1);
        read_chk("carry_lo_after", 12'hB00, 32'd1);
        set_csr(12'hB80, 2'b01, 0); mid(); nxt();
        set_csr(12'hB00, 2'b01, 32'hFFFF_FFFF); mid(); nxt();
        set_csr(12'hB00, 2'b01, 32'h0000_1234); mid(); check("nocarry_old_lo", bus.csr_rdata, 32'hFFFF_FFFF); nxt();
        read_chk("nocarry_hi", 12'hB80, 32'd0);
        read_chk("nocarry_lo", 12'hB00, 32'h0000_1235);
        set_csr(12'hB80, 2'b01, 32'hFFFF_FFFF); mid(); nxt();
        set_csr(12'hB00, 2'b01, 32'hFFFF_FFFF); mid(); check("hi_masked", 32'd0, 32'd0 & bus.csr_rdata); nxt();
        read_chk("wrap_hi_top", 12'hB80, 32'h0000_00FF);
        read_chk("wrap_hi_zero", 12'hB80, 32'd0);
        read_chk("wrap_lo", 12'hB00, 32'd1);

        set_csr(12'hF14, 2'b01, 32'h55); mid();
        check("hartid_wr_illegal", 32'(bus.csr_illegal), 32'd1);
        check("hartid_wr_rdata", bus.csr_rdata, 32'd0);
        nxt();
        read_chk("hartid_value", 12'hF14, HART_ID);
        set_csr(12'h7C0, 2'b10, 0); mid(); check("unimpl_illegal", 32'(bus.csr_illegal), 32'd1); nxt();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset_x = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                reset_x = 1'b1;
            end
            bus.csr_addr  = addr_tab[$urandom_range(0, 15)];
            bus.csr_op    = 2'($urandom_range(0, 3));
            bus.csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            bus.exc_valid = ($urandom_range(0, 9) == 0);
            bus.exc_cause = 4'($urandom_range(0, 15));
            bus.exc_pc    = $urandom() & 32'hFFFF_FFFC;
            bus.exc_tval  = $urandom();
            bus.mret      = ($urandom_range(0, 9) == 0);
            bus.retire    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.irq_ext = ~bus.irq_ext;
            if ($urandom_range(0, 7) == 0) bus.irq_sw  = ~bus.irq_sw;
            if ($urandom_range(0, 7) == 0) bus.irq_tmr = ~bus.irq_tmr;
            @(posedge clk); #1;
        end
        idle();
        mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
